// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencing controller: state encoding,
// control bundle layout and default timing parameters.
package pipe_pkg;

  localparam int REG_W = 5;

  localparam int DEF_START_BUBBLES = 4;
  localparam int DEF_MEM_TIMEOUT   = 255;
  localparam int DEF_CNT_W         = 32;

  localparam logic [1:0] ST_START    = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  typedef struct packed {
    logic pc_wr_en;
    logic if_id_wr_en;
    logic if_id_flush;
    logic id_ex_wr_en;
    logic id_ex_flush;
    logic ex_mem_wr_en;
  } ctrl_t;

  // Field order: pc_wr, if_id_wr, if_id_flush, id_ex_wr, id_ex_flush, ex_mem_wr
  localparam ctrl_t CTRL_START    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam ctrl_t CTRL_HOLD     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam ctrl_t CTRL_JUMP     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam ctrl_t CTRL_NORMAL   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  // Width able to hold values 0..n, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the load in EX writes a register the ID instruction
// reads. $zero is never a real dependency.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_use_rt,
  input  logic [REG_W-1:0] EX_rt,
  input  logic             EX_Mem_rd,
  output logic             load_use
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (EX_rt == ID_rs);
  assign rt_match = ID_use_rt & (EX_rt == ID_rt);
  assign load_use = EX_Mem_rd & (EX_rt != '0) & (rs_match | rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: stage enables and
// flushes, start-up bubbles, memory-wait hold, stall counter and timeout flag.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_START    | post-reset bubbles: PC held, IF/ID and ID/EX flushed
// ST_RUN      | normal flow with branch/load-use/jump resolution
// ST_MEM_WAIT | data memory busy: every stage held
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int START_BUBBLES = DEF_START_BUBBLES,
  parameter int MEM_TIMEOUT   = DEF_MEM_TIMEOUT,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_use_rt,
  input  logic             ID_Jump,
  input  logic [4:0]       EX_rt,
  input  logic             EX_Mem_rd,
  input  logic             EX_Branch_taken,
  input  logic             MEM_req,
  input  logic             MEM_ready,
  output logic             PC_wr_en,
  output logic             IF_ID_wr_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_wr_en,
  output logic             ID_EX_flush,
  output logic             EX_MEM_wr_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_timeout
);

  localparam int SW = cnt_width(START_BUBBLES);
  localparam int WW = cnt_width(MEM_TIMEOUT);

  localparam logic [SW-1:0] START_LAST = SW'((START_BUBBLES > 0) ? START_BUBBLES - 1 : 0);
  localparam logic [WW-1:0] WAIT_MAX   = WW'(MEM_TIMEOUT);
  // With no bubbles requested the first post-reset cycle is already RUN.
  localparam logic [1:0]    RESET_STATE = (START_BUBBLES > 0) ? ST_START : ST_RUN;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [SW-1:0] start_cnt;
  logic [SW-1:0] start_cnt_nxt;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_cnt_nxt;
  logic          timeout_hit;
  logic          load_use;
  logic          mem_stall;
  logic          mem_done;
  ctrl_t         ctrl;

  hazard_detect u_hazard_detect (
    .ID_rs     (ID_rs),
    .ID_rt     (ID_rt),
    .ID_use_rt (ID_use_rt),
    .EX_rt     (EX_rt),
    .EX_Mem_rd (EX_Mem_rd),
    .load_use  (load_use)
  );

  assign mem_stall = MEM_req & ~MEM_ready;
  // A request withdrawn mid-wait releases the hold just like a ready.
  assign mem_done  = MEM_ready | ~MEM_req;

  always_comb begin
    ctrl          = CTRL_START;
    state_nxt     = state;
    start_cnt_nxt = start_cnt;
    wait_cnt_nxt  = wait_cnt;
    timeout_hit   = 1'b0;

    case (state)
      ST_START: begin
        ctrl          = CTRL_START;
        start_cnt_nxt = start_cnt + SW'(1);
        if (start_cnt == START_LAST) begin
          state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        if (mem_stall) begin
          ctrl         = CTRL_HOLD;
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = WW'(1);
          timeout_hit  = (WW'(1) >= WAIT_MAX);
        end else if (EX_Branch_taken) begin
          ctrl = CTRL_REDIRECT;
        end else if (load_use) begin
          ctrl = CTRL_LOAD_USE;
        end else if (ID_Jump) begin
          ctrl = CTRL_JUMP;
        end else begin
          ctrl = CTRL_NORMAL;
        end
      end

      ST_MEM_WAIT: begin
        ctrl = CTRL_HOLD;
        if (mem_done) begin
          state_nxt = ST_RUN;
        end else begin
          wait_cnt_nxt = (wait_cnt >= WAIT_MAX) ? wait_cnt : wait_cnt + WW'(1);
          timeout_hit  = (wait_cnt_nxt >= WAIT_MAX);
        end
      end

      default: begin
        ctrl      = CTRL_START;
        state_nxt = ST_START;
      end
    endcase

    if (reset) begin
      ctrl = CTRL_START;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RESET_STATE;
      start_cnt   <= '0;
      wait_cnt    <= '0;
      stall_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      start_cnt <= start_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      if (!ctrl.pc_wr_en) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (timeout_hit) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  assign PC_wr_en     = ctrl.pc_wr_en;
  assign IF_ID_wr_en  = ctrl.if_id_wr_en;
  assign IF_ID_flush  = ctrl.if_id_flush;
  assign ID_EX_wr_en  = ctrl.id_ex_wr_en;
  assign ID_EX_flush  = ctrl.id_ex_flush;
  assign EX_MEM_wr_en = ctrl.ex_mem_wr_en;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes expectations from a
// behavioural model, a negedge monitor pops and compares every cycle.
module tb_hazard_ctrl;

  localparam int SB = 4;
  localparam int TO = 5;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    ID_rs, ID_rt, EX_rt;
  logic          ID_use_rt, ID_Jump, EX_Mem_rd, EX_Branch_taken, MEM_req, MEM_ready;
  logic          PC_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_wr_en, ID_EX_flush, EX_MEM_wr_en;
  logic [CW-1:0] stall_cnt;
  logic          mem_timeout;
  logic [5:0]    dut_ctl;

  always #5 clk = ~clk;

  hazard_ctrl #(.START_BUBBLES(SB), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .ID_rs           (ID_rs),
    .ID_rt           (ID_rt),
    .ID_use_rt       (ID_use_rt),
    .ID_Jump         (ID_Jump),
    .EX_rt           (EX_rt),
    .EX_Mem_rd       (EX_Mem_rd),
    .EX_Branch_taken (EX_Branch_taken),
    .MEM_req         (MEM_req),
    .MEM_ready       (MEM_ready),
    .PC_wr_en        (PC_wr_en),
    .IF_ID_wr_en     (IF_ID_wr_en),
    .IF_ID_flush     (IF_ID_flush),
    .ID_EX_wr_en     (ID_EX_wr_en),
    .ID_EX_flush     (ID_EX_flush),
    .EX_MEM_wr_en    (EX_MEM_wr_en),
    .stall_cnt       (stall_cnt),
    .mem_timeout     (mem_timeout)
  );

  assign dut_ctl = {PC_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_wr_en, ID_EX_flush, EX_MEM_wr_en};

  // {pc_wr, if_id_wr, if_id_flush, id_ex_wr, id_ex_flush, ex_mem_wr}
  localparam logic [5:0] E_START  = 6'b011111;
  localparam logic [5:0] E_HOLD   = 6'b000000;
  localparam logic [5:0] E_BRANCH = 6'b111111;
  localparam logic [5:0] E_LDUSE  = 6'b000111;
  localparam logic [5:0] E_JUMP   = 6'b111101;
  localparam logic [5:0] E_NORMAL = 6'b110101;

  typedef struct {
    int            cyc;
    logic [5:0]    ctl;
    logic [CW-1:0] stall;
    logic          to;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  // Reference model state: bubbles still owed, wait run length, counters.
  int            boot_left = SB;
  bit            waiting   = 0;
  int            wait_len  = 0;
  logic [CW-1:0] stall_m   = '0;
  bit            to_m      = 0;

  task automatic step(input bit r, input logic [4:0] rs, input logic [4:0] rt,
                      input bit use_rt, input bit jmp, input logic [4:0] ert,
                      input bit mrd, input bit br, input bit req, input bit rdy);
    exp_t e;
    bit   lu;
    @(posedge clk);
    #1;
    reset = r; ID_rs = rs; ID_rt = rt; ID_use_rt = use_rt; ID_Jump = jmp;
    EX_rt = ert; EX_Mem_rd = mrd; EX_Branch_taken = br; MEM_req = req; MEM_ready = rdy;
    e.cyc   = cyc;
    e.stall = stall_m;
    e.to    = to_m;
    lu = mrd && (ert != 5'd0) && ((ert == rs) || (use_rt && (ert == rt)));
    if (r) begin
      e.ctl     = E_START;
      boot_left = SB;
      waiting   = 0;
      wait_len  = 0;
      stall_m   = '0;
      to_m      = 0;
    end else begin
      if (boot_left > 0) begin
        e.ctl = E_START;
        boot_left--;
      end else if (waiting) begin
        e.ctl = E_HOLD;
        if (req && !rdy) begin
          wait_len++;
          if (wait_len >= TO) to_m = 1;
        end else begin
          waiting = 0;
        end
      end else if (req && !rdy) begin
        e.ctl    = E_HOLD;
        waiting  = 1;
        wait_len = 1;
        if (wait_len >= TO) to_m = 1;
      end else if (br) begin
        e.ctl = E_BRANCH;
      end else if (lu) begin
        e.ctl = E_LDUSE;
      end else if (jmp) begin
        e.ctl = E_JUMP;
      end else begin
        e.ctl = E_NORMAL;
      end
      if (e.ctl[5] == 1'b0) stall_m = stall_m + 1;
    end
    q.push_back(e);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      tests++;
      if (dut_ctl !== mon_e.ctl) begin
        fails++;
        $display("FAIL ctl cyc %0d got %b exp %b", mon_e.cyc, dut_ctl, mon_e.ctl);
      end
      tests++;
      if (stall_cnt !== mon_e.stall) begin
        fails++;
        $display("FAIL stall_cnt cyc %0d got %0d exp %0d", mon_e.cyc, stall_cnt, mon_e.stall);
      end
      tests++;
      if (mem_timeout !== mon_e.to) begin
        fails++;
        $display("FAIL mem_timeout cyc %0d got %b exp %b", mon_e.cyc, mem_timeout, mon_e.to);
      end
    end
  end

  initial begin
    int hold_lo;
    bit rq, rd;
    reset = 1'b1; ID_rs = '0; ID_rt = '0; ID_use_rt = 0; ID_Jump = 0;
    EX_rt = '0; EX_Mem_rd = 0; EX_Branch_taken = 0; MEM_req = 0; MEM_ready = 0;

    // Reset, start bubbles, then normal flow
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(7);

    // Load-use on rs, then the load has left EX
    step(0, 5'd8, 5'd9, 0, 0, 5'd8, 1, 0, 0, 0);
    idle(2);
    // Load to $zero never stalls
    step(0, 5'd0, 5'd9, 0, 0, 5'd0, 1, 0, 0, 0);
    // Load-use on rt only when rt is a source
    step(0, 5'd4, 5'd8, 0, 0, 5'd8, 1, 0, 0, 0);
    step(0, 5'd4, 5'd8, 1, 0, 5'd8, 1, 0, 0, 0);
    // Jump alone, then load-use beats jump
    step(0, 5'd4, 5'd5, 0, 1, 5'd3, 0, 0, 0, 0);
    step(0, 5'd8, 5'd5, 0, 1, 5'd8, 1, 0, 0, 0);
    step(0, 5'd8, 5'd5, 0, 1, 5'd3, 0, 0, 0, 0);
    // Branch beats jump and load-use
    step(0, 5'd8, 5'd5, 0, 1, 5'd8, 1, 1, 0, 0);
    idle(1);

    // Memory wait 3 cycles then ready, branch held across the wait
    for (int i = 0; i < 3; i++) step(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 1, 1, 0);
    step(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 1, 1, 1);
    step(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 1, 0, 0);
    idle(2);

    // Timeout: ready held low past the limit, flag sticks afterwards
    for (int i = 0; i < 8; i++) step(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 1, 0);
    step(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 1, 1);
    idle(3);
    // Request withdrawn mid-wait releases the hold
    step(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 1, 0);
    step(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 1, 0);
    step(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 0, 0);
    idle(2);

    // Reset for one cycle in the middle of a wait
    for (int i = 0; i < 3; i++) step(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 1, 0);
    step(1, 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 1, 0);
    step(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 1, 1);
    idle(2);

    // Randomised traffic with occasional long waits and resets
    hold_lo = 0;
    for (int i = 0; i < 3000; i++) begin
      rq = ($urandom_range(0, 3) == 0);
      if (hold_lo > 0) begin
        rq = 1; rd = 0; hold_lo--;
      end else begin
        rd = ($urandom_range(0, 2) != 0);
        if (rq && $urandom_range(0, 15) == 0) hold_lo = $urandom_range(3, 8);
      end
      step(($urandom_range(0, 199) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
           5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
           $urandom_range(0, 4) == 0, rq, rd);
    end

    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Drives the write-enable and flush controls of the PC, the IF/ID register, the ID/EX register (enable-capable variant) and the EX/MEM register.
- Resolves load-use hazards, taken-branch and jump redirects, and multi-cycle data-memory waits.
- Keeps a stall-cycle performance counter and a sticky memory-timeout error flag.

Parameters:
- START_BUBBLES, 4: cycles after reset during which the PC is held and the IF/ID and ID/EX registers are flushed.
- MEM_TIMEOUT, 255: maximum number of consecutive MEM_WAIT cycles before the error flag is raised.
- CNT_W, 32: width of the stall counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ID_rs  in  5  rs field of the instruction in ID.
- ID_rt  in  5  rt field of the instruction in ID.
- ID_use_rt  in  1  the ID instruction reads rt as a source.
- ID_Jump  in  1  the ID instruction is j, jal or jr.
- EX_rt  in  5  rt field of the instruction in EX.
- EX_Mem_rd  in  1  the EX instruction is a load.
- EX_Branch_taken  in  1  the EX branch resolved as taken.
- MEM_req  in  1  the MEM stage accesses data memory this cycle.
- MEM_ready  in  1  data memory completes the access this cycle.
- PC_wr_en  out  1  PC update enable.
- IF_ID_wr_en  out  1  IF/ID register load enable.
- IF_ID_flush  out  1  IF/ID register clear.
- ID_EX_wr_en  out  1  ID/EX register load enable.
- ID_EX_flush  out  1  ID/EX register clear.
- EX_MEM_wr_en  out  1  EX/MEM register load enable.
- stall_cnt  out  CNT_W  number of cycles in which PC_wr_en was 0.
- mem_timeout  out  1  sticky error: a memory wait exceeded MEM_TIMEOUT cycles.

Behaviour:
- States are START, RUN and MEM_WAIT.
- Control outputs are combinational from the current state and the inputs.
- stall_cnt, mem_timeout, the state register and the counters are registered.
- Reset (synchronous, takes effect on the next rising edge, also when asserted mid-wait):
  - state goes to START; start counter and wait counter go to 0; stall_cnt and mem_timeout go to 0.
  - While reset is high the outputs are the START values.
- START:
  - PC_wr_en = 0, IF_ID_wr_en = 1, IF_ID_flush = 1, ID_EX_wr_en = 1, ID_EX_flush = 1, EX_MEM_wr_en = 1.
  - The start counter increments each cycle.
  - Move to RUN after exactly START_BUBBLES cycles.
  - START_BUBBLES = 0 means RUN is entered on the first cycle after reset.
- RUN priority, highest first:
  - (1) Memory wait, MEM_req & !MEM_ready: PC_wr_en = IF_ID_wr_en = ID_EX_wr_en = EX_MEM_wr_en = 0 and no flushes. Next state is MEM_WAIT; wait counter is set to 1.
  - (2) Taken branch, EX_Branch_taken: IF_ID_flush = 1 and ID_EX_flush = 1; all enables 1.
  - (3) Load-use, EX_Mem_rd & EX_rt != 0 & (EX_rt == ID_rs | (ID_use_rt & EX_rt == ID_rt)): PC_wr_en = 0, IF_ID_wr_en = 0, ID_EX_flush = 1 (one bubble). Exactly one stall cycle, because the load then leaves EX.
  - (4) Jump, ID_Jump: IF_ID_flush = 1.
  - (5) Otherwise all enables are 1 and all flushes are 0.
  - A jump together with a taken branch resolves as (2), because the branch is older.
  - A load-use together with a jump resolves as (3); the jump is re-evaluated on the following cycle.
- MEM_WAIT:
  - Hold all stages: all enables 0, no flushes.
  - When MEM_ready = 1, the current cycle still holds; the state returns to RUN next cycle and the RUN rules apply again. Any branch or hazard that was pending in EX or ID is therefore resolved after the wait.
  - The wait counter increments each MEM_WAIT cycle and saturates.
  - If the counter reaches MEM_TIMEOUT while MEM_ready = 0, set mem_timeout = 1. It stays set until reset. The block stays in MEM_WAIT; there is no automatic abort.
  - MEM_req dropping to 0 while in MEM_WAIT is treated as MEM_ready.
- stall_cnt:
  - Increments by 1 in every cycle with PC_wr_en = 0, including START and reset-exit cycles but not cycles in which reset is high.
  - Wraps modulo 2^CNT_W.

Decomposition:
- A shared package pipe_pkg holds the state encoding constants, the reset-default control bundle, and MEM_TIMEOUT/START_BUBBLES defaults.
- One sub-module, hazard_detect, holds the purely combinational load-use comparator (inputs ID_rs, ID_rt, ID_use_rt, EX_rt, EX_Mem_rd; output load_use).
- The FSM, counters and priority mux stay in hazard_ctrl.

Test Plan:
- Reset then release with START_BUBBLES = 4:
  - PC_wr_en = 0 and both flushes = 1 for 4 cycles; RUN on cycle 5.
  - stall_cnt = 4.
- Load-use, lw writing $t0 in EX (EX_rt = 8, EX_Mem_rd = 1) with ID_rs = 8:
  - one cycle with PC_wr_en = 0, IF_ID_wr_en = 0, ID_EX_flush = 1; normal flow the next cycle.
  - The same case with EX_rt = 0 must give no stall.
- EX_Branch_taken = 1 with ID_Jump = 1 and a load-use match in the same cycle:
  - IF_ID_flush = 1, ID_EX_flush = 1, PC_wr_en = 1; stall_cnt unchanged.
- MEM_req = 1 and MEM_ready = 0 for 3 cycles, then MEM_ready = 1:
  - all enables 0 for 4 cycles with no flushes, then RUN.
  - stall_cnt increases by 4.
  - An EX_Branch_taken held during the wait produces its flush only on the first RUN cycle.
- MEM_TIMEOUT = 5, MEM_ready held at 0:
  - mem_timeout rises when the wait counter reaches 5 and stays 1 after MEM_ready returns.
  - It clears only on reset.
- Assert reset for one cycle mid-MEM_WAIT:
  - state goes to START, counters and mem_timeout are 0, and the START output pattern appears on the next cycle.
